// File: rtl/fifo_inst_gen.sv
// fifo_inst_gen: FIFO instruction encoder with occupancy tracking and response buffer; stats gated by FIFO_INST_GEN_STATS_EN
module fifo_inst_gen #(
  parameter int DEPTH = 16,
  parameter int RSP_DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int RW = $clog2(RSP_DEPTH) + 1,
  localparam int PW = $clog2(RSP_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_op,
  input  logic [31:0]   cmd_data,
  output logic [33:0]   inst,
  input  logic [31:0]   res,
  input  logic          read_valid,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          cmd_err,
  output logic [15:0]   wr_total,
  output logic [15:0]   rd_total
);
  logic [33:0]   inst_q, inst_d;
  logic [CW-1:0] count_q, count_d;
  logic [RW-1:0] out_q, out_d, rsp_count_q, rsp_count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          cmd_err_q, cmd_err_d;
  logic [31:0]   mem_q [RSP_DEPTH];
  logic          acc, wr_ok, rd_ok, push, pop;
  // Credit check, command decode and next-state for counters and pointers
  always_comb begin
    cmd_ready   = ({1'b0, out_q} + {1'b0, rsp_count_q}) < (RW + 1)'(RSP_DEPTH);
    full        = count_q == CW'(DEPTH);
    empty       = count_q == '0;
    acc         = cmd_valid && cmd_ready;
    wr_ok       = acc && !cmd_op && !full;
    rd_ok       = acc && cmd_op && !empty;
    push        = read_valid && out_q != '0;
    rsp_valid   = rsp_count_q != '0;
    pop         = rsp_valid && rsp_ready;
    inst_d      = wr_ok ? {2'b10, cmd_data} : rd_ok ? {2'b01, 32'h0} : 34'h0;
    count_d     = count_q + CW'(wr_ok) - CW'(rd_ok);
    out_d       = out_q + RW'(rd_ok) - RW'(push);
    rsp_count_d = rsp_count_q + RW'(push) - RW'(pop);
    wr_ptr_d    = wr_ptr_q + PW'(push);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    cmd_err_d   = (acc && !wr_ok && !rd_ok) || (read_valid && out_q == '0);
  end
  // State registers; buffer storage needs no reset because rsp_data is gated by rsp_valid
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= res;
    if (rst) begin
      inst_q      <= '0;
      count_q     <= '0;
      out_q       <= '0;
      rsp_count_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cmd_err_q   <= 1'b0;
    end else begin
      inst_q      <= inst_d;
      count_q     <= count_d;
      out_q       <= out_d;
      rsp_count_q <= rsp_count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cmd_err_q   <= cmd_err_d;
    end
  end
  assign inst     = inst_q;
  assign count    = count_q;
  assign cmd_err  = cmd_err_q;
  assign rsp_data = rsp_valid ? mem_q[rd_ptr_q] : 32'h0;
`ifdef FIFO_INST_GEN_STATS_EN
  logic [15:0] wr_total_q, wr_total_d, rd_total_q, rd_total_d;
  // Saturating counts of issued writes and reads
  always_comb begin
    wr_total_d = wr_total_q + 16'(wr_ok && wr_total_q != 16'hFFFF);
    rd_total_d = rd_total_q + 16'(rd_ok && rd_total_q != 16'hFFFF);
  end
  // Statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_total_q <= '0;
      rd_total_q <= '0;
    end else begin
      wr_total_q <= wr_total_d;
      rd_total_q <= rd_total_d;
    end
  end
  assign wr_total = wr_total_q;
  assign rd_total = rd_total_q;
`else
  assign wr_total = 16'h0;
  assign rd_total = 16'h0;
`endif
endmodule

// File: tb/tb_fifo_inst_gen.sv
// tb_fifo_inst_gen: directed self-checking bench for fifo_inst_gen
module tb_fifo_inst_gen;
  logic        clk = 0, rst = 1, cmd_valid = 0, cmd_op = 0, read_valid = 0, rsp_ready = 0;
  logic [31:0] cmd_data = 0, res = 0, rsp_data;
  logic [33:0] inst;
  logic        cmd_ready, rsp_valid, full, empty, cmd_err;
  logic [4:0]  count;
  logic [15:0] wr_total, rd_total;
  int checks = 0, failures = 0;
`ifdef FIFO_INST_GEN_STATS_EN
  localparam logic [15:0] EXP_WR = 16, EXP_RD = 7;
`else
  localparam logic [15:0] EXP_WR = 0, EXP_RD = 0;
`endif
  fifo_inst_gen dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .inst(inst), .res(res), .read_valid(read_valid), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .count(count), .full(full), .empty(empty),
    .cmd_err(cmd_err), .wr_total(wr_total), .rd_total(rd_total)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, o, e);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_inst"}, 64'(inst), 0);
    chk({tag, "_count"}, 64'(count), 0);
    chk({tag, "_empty"}, 64'(empty), 1);
    chk({tag, "_full"}, 64'(full), 0);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 1);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 0);
    chk({tag, "_rsp_data"}, 64'(rsp_data), 0);
    chk({tag, "_cmd_err"}, 64'(cmd_err), 0);
    chk({tag, "_wr_total"}, 64'(wr_total), 0);
    chk({tag, "_rd_total"}, 64'(rd_total), 0);
  endtask
  initial begin
    step; step;
    chk_reset("rst0");
    rst = 0;
    cmd_valid = 1; cmd_op = 0; cmd_data = 32'hA5A5_0001;
    step;
    chk("wr1_inst", 64'(inst), 64'h2_A5A5_0001);
    chk("wr1_count", 64'(count), 1);
    chk("wr1_empty", 64'(empty), 0);
    cmd_valid = 0;
    step;
    chk("wr1_nop", 64'(inst), 0);
    cmd_valid = 1;
    for (int i = 1; i < 16; i++) begin
      cmd_data = i;
      step;
    end
    chk("fill_full", 64'(full), 1);
    chk("fill_count", 64'(count), 16);
    chk("fill_inst", 64'(inst), 64'h2_0000_000F);
    cmd_data = 32'h1234_5678;
    step;
    chk("ovf_inst", 64'(inst), 0);
    chk("ovf_err", 64'(cmd_err), 1);
    chk("ovf_count", 64'(count), 16);
    cmd_valid = 0;
    step;
    chk("ovf_err_clr", 64'(cmd_err), 0);
    cmd_valid = 1; cmd_op = 1;
    step;
    chk("rd_inst", 64'(inst), 64'h1_0000_0000);
    chk("rd_count", 64'(count), 15);
    cmd_valid = 0;
    step;
    chk("rd_nop", 64'(inst), 0);
    step;
    chk("rd_wait", 64'(rsp_valid), 0);
    read_valid = 1; res = 32'hDEAD_BEEF;
    step;
    read_valid = 0;
    chk("rsp_valid", 64'(rsp_valid), 1);
    chk("rsp_data", 64'(rsp_data), 64'hDEAD_BEEF);
    rsp_ready = 1;
    step;
    rsp_ready = 0;
    chk("rsp_pop", 64'(rsp_valid), 0);
    cmd_valid = 1; cmd_op = 1;
    for (int i = 0; i < 3; i++) step;
    chk("bp_ready3", 64'(cmd_ready), 1);
    step;
    chk("bp_ready4", 64'(cmd_ready), 0);
    chk("bp_count", 64'(count), 11);
    step;
    chk("bp_block_inst", 64'(inst), 0);
    chk("bp_block_count", 64'(count), 11);
    chk("bp_block_err", 64'(cmd_err), 0);
    cmd_valid = 0;
    read_valid = 1;
    for (int i = 0; i < 4; i++) begin
      res = 32'h100 + i;
      step;
    end
    read_valid = 0;
    chk("bp_full_ready", 64'(cmd_ready), 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("order_%0d", i), 64'(rsp_data), 64'h100 + i);
      rsp_ready = 1;
      step;
      rsp_ready = 0;
      if (i == 0) chk("bp_ready_back", 64'(cmd_ready), 1);
    end
    chk("drain_valid", 64'(rsp_valid), 0);
    read_valid = 1; res = 32'hBAD0_0000;
    step;
    read_valid = 0;
    chk("spur_err", 64'(cmd_err), 1);
    chk("spur_rsp", 64'(rsp_valid), 0);
    cmd_valid = 1; cmd_op = 1;
    step; step;
    cmd_valid = 0;
    chk("pre_rst_count", 64'(count), 9);
    chk("pre_rst_wr_total", 64'(wr_total), 64'(EXP_WR));
    chk("pre_rst_rd_total", 64'(rd_total), 64'(EXP_RD));
    rst = 1;
    step;
    chk_reset("rst1");
    rst = 0;
    read_valid = 1; res = 32'hCAFE_F00D;
    step;
    read_valid = 0;
    chk("late_err", 64'(cmd_err), 1);
    chk("late_rsp", 64'(rsp_valid), 0);
    cmd_valid = 1; cmd_op = 1;
    step;
    cmd_valid = 0;
    chk("rd_empty_inst", 64'(inst), 0);
    chk("rd_empty_err", 64'(cmd_err), 1);
    chk("rd_empty_count", 64'(count), 0);
    chk("rd_empty_total", 64'(rd_total), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
